// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared state codes, widths and default timing for the Simon game
package simon_pkg;

  localparam int LEVEL_W = 8;

  localparam int DEF_ON_CYCLES      = 25_000_000;
  localparam int DEF_OFF_CYCLES     = 12_500_000;
  localparam int DEF_TIMEOUT_CYCLES = 250_000_000;
  localparam int DEF_MAX_LEN        = 16;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_SEED     = 4'd1;
  localparam state_t S_REWIND   = 4'd2;
  localparam state_t S_SHOW_ON  = 4'd3;
  localparam state_t S_SHOW_OFF = 4'd4;
  localparam state_t S_STEP     = 4'd5;
  localparam state_t S_GAP      = 4'd6;
  localparam state_t S_INPUT    = 4'd7;
  localparam state_t S_ACCEPT   = 4'd8;
  localparam state_t S_WIN      = 4'd9;
  localparam state_t S_LOSE     = 4'd10;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold values 0..v, never less than one.
  function automatic int width_for(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter; done while the count sits at zero
module phase_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/simon_game_controller.sv
// rtl/simon_game_controller.sv - Simon game FSM driving sequence_generator strobes and LEDs
module simon_game_controller
  import simon_pkg::*;
#(
  parameter int ON_CYCLES      = DEF_ON_CYCLES,
  parameter int OFF_CYCLES     = DEF_OFF_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_LEN        = DEF_MAX_LEN
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [1:0]         i_btn,
  input  logic [1:0]         i_seq,
  output logic               o_randomize,
  output logic               o_start_over,
  output logic               o_next,
  output logic [1:0]         o_led,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_win,
  output logic               o_fail
);

  localparam int TIMER_W = width_for(max3(ON_CYCLES, OFF_CYCLES, TIMEOUT_CYCLES));
  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TO_LOAD  = TIMER_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t               r_state;
  logic [LEVEL_W-1:0]   r_idx;
  logic [LEVEL_W-1:0]   r_len;
  logic                 r_input_pass;
  logic                 r_randomize, r_start_over, r_next, r_win, r_fail;
  logic [1:0]           r_led;

  state_t               w_next;
  logic [LEVEL_W-1:0]   w_idx_inc;
  logic                 w_done, w_timeout, w_btn_ok, w_load;
  logic [TIMER_W-1:0]   w_load_val;
  logic [1:0]           w_led_next;

  assign w_idx_inc = r_idx + 1'b1;
  assign w_btn_ok  = (i_btn == i_seq) && (i_btn != 2'b11);
  assign w_timeout = TIMEOUT_EN && w_done;
  assign w_load    = (w_next != r_state);

  phase_timer #(.W(TIMER_W)) u_phase_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_done  (w_done)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (i_start) w_next = S_SEED;
      S_SEED:     w_next = S_REWIND;
      S_REWIND:   w_next = r_input_pass ? S_GAP : S_SHOW_ON;
      S_SHOW_ON:  if (w_done) w_next = S_SHOW_OFF;
      S_SHOW_OFF: if (w_done) w_next = (w_idx_inc == r_len) ? S_REWIND : S_STEP;
      S_STEP:     w_next = S_SHOW_ON;
      S_GAP:      if (w_done) w_next = S_INPUT;
      // A press wins over a simultaneous timeout.
      S_INPUT: begin
        if (i_btn != 2'b00) w_next = w_btn_ok ? S_ACCEPT : S_LOSE;
        else if (w_timeout) w_next = S_LOSE;
      end
      S_ACCEPT: begin
        if (w_idx_inc < r_len)                  w_next = S_INPUT;
        else if (r_len == LEVEL_W'(MAX_LEN))    w_next = S_WIN;
        else                                    w_next = S_REWIND;
      end
      S_WIN, S_LOSE: if (i_start) w_next = S_SEED;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load_val = '0;
    case (w_next)
      S_SHOW_ON:         w_load_val = ON_LOAD;
      S_SHOW_OFF, S_GAP: w_load_val = OFF_LOAD;
      S_INPUT:           w_load_val = TO_LOAD;
      default:           w_load_val = '0;
    endcase
  end

  // seq only becomes valid after the strobe edge, so shown elements trail the state by a cycle.
  always_comb begin
    w_led_next = 2'b00;
    if (w_next == S_WIN)                              w_led_next = 2'b11;
    else if (r_state == S_SHOW_ON)                    w_led_next = i_seq;
    else if (r_state == S_INPUT && w_next != S_LOSE)  w_led_next = i_btn;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_len        <= '0;
      r_input_pass <= 1'b0;
      r_randomize  <= 1'b0;
      r_start_over <= 1'b0;
      r_next       <= 1'b0;
      r_win        <= 1'b0;
      r_fail       <= 1'b0;
      r_led        <= 2'b00;
    end else begin
      r_state      <= w_next;
      r_randomize  <= (w_next == S_SEED);
      r_start_over <= (w_next == S_REWIND);
      r_next       <= (w_next == S_STEP) || (w_next == S_ACCEPT);
      r_win        <= (w_next == S_WIN);
      r_fail       <= (w_next == S_LOSE);
      r_led        <= w_led_next;

      if (r_state == S_REWIND)                                r_idx <= '0;
      else if (r_state == S_SHOW_OFF && w_done)               r_idx <= w_idx_inc;
      else if (r_state == S_ACCEPT)                           r_idx <= w_idx_inc;

      if (w_next == S_SEED)                                   r_len <= LEVEL_W'(1);
      else if (r_state == S_ACCEPT && w_next == S_REWIND)     r_len <= r_len + 1'b1;

      if (r_state == S_SHOW_OFF && w_next == S_REWIND)        r_input_pass <= 1'b1;
      else if (r_state == S_REWIND)                           r_input_pass <= 1'b0;
    end
  end

  assign o_randomize  = r_randomize;
  assign o_start_over = r_start_over;
  assign o_next       = r_next;
  assign o_led        = r_led;
  assign o_level      = r_len;
  assign o_win        = r_win;
  assign o_fail       = r_fail;

endmodule

// File: tb/tb_simon_game_controller.sv
// tb/tb_simon_game_controller.sv - directed vector bench for simon_game_controller
module tb_simon_game_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] btn = 2'b00;
  logic [1:0] seq;
  logic       o_randomize, o_start_over, o_next, o_win, o_fail;
  logic [1:0] o_led;
  logic [7:0] o_level;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  simon_game_controller #(
    .ON_CYCLES(4), .OFF_CYCLES(2), .TIMEOUT_CYCLES(20), .MAX_LEN(3)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_btn(btn), .i_seq(seq),
    .o_randomize(o_randomize), .o_start_over(o_start_over), .o_next(o_next),
    .o_led(o_led), .o_level(o_level), .o_win(o_win), .o_fail(o_fail)
  );

  // sequence_generator stand-in: fixed sequence 01,10,10
  logic [1:0] gen_tbl [3] = '{2'b01, 2'b10, 2'b10};
  int gen_pos = 0;
  always @(posedge clk) begin
    if (o_randomize || o_start_over) gen_pos <= 0;
    else if (o_next && gen_pos < 2)  gen_pos <= gen_pos + 1;
  end
  assign seq = gen_tbl[gen_pos];

  typedef struct {
    logic        s;
    logic [1:0]  b;
    logic [14:0] e;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [14:0] outs();
    return {o_randomize, o_start_over, o_next, o_led, o_level, o_win, o_fail};
  endfunction

  function automatic logic [14:0] ex(input logic r, input logic so, input logic nx,
                                     input logic [1:0] led, input logic [7:0] lvl,
                                     input logic w, input logic f);
    return {r, so, nx, led, lvl, w, f};
  endfunction

  task automatic add(input logic s, input logic [1:0] b, input logic [14:0] e, input int n = 1);
    vec_t v;
    v.s = s; v.b = b; v.e = e;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  task automatic press(input logic [1:0] b);
    btn = b;
    tick();
    btn = 2'b00;
  endtask

  task automatic begin_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("seed_randomize", o_randomize, 1);
    chk("seed_level", o_level, 1);
  endtask

  int c_so, c_nx, c_lit;

  initial begin
    tick(2);
    chk("reset_outputs", outs(), 0);
    rst = 1'b0;
    tick();
    chk("idle_outputs", outs(), 0);

    // round 1 show and entry, then round 2 show with ignored presses and start
    add(1, 0, ex(1,0,0,2'b00,1,0,0));
    add(0, 0, ex(0,1,0,2'b00,1,0,0));
    add(0, 0, ex(0,0,0,2'b00,1,0,0));
    add(0, 0, ex(0,0,0,2'b01,1,0,0), 4);
    add(0, 0, ex(0,0,0,2'b00,1,0,0));
    add(0, 0, ex(0,1,0,2'b00,1,0,0));
    add(0, 0, ex(0,0,0,2'b00,1,0,0), 3);
    add(0, 1, ex(0,0,1,2'b01,1,0,0));
    add(0, 0, ex(0,1,0,2'b00,2,0,0));
    add(0, 0, ex(0,0,0,2'b00,2,0,0));
    add(0, 0, ex(0,0,0,2'b01,2,0,0));
    add(0, 2, ex(0,0,0,2'b01,2,0,0));
    add(1, 0, ex(0,0,0,2'b01,2,0,0));
    add(0, 0, ex(0,0,0,2'b01,2,0,0));
    add(0, 0, ex(0,0,0,2'b00,2,0,0));
    add(0, 1, ex(0,0,1,2'b00,2,0,0));
    add(0, 0, ex(0,0,0,2'b00,2,0,0));
    add(0, 0, ex(0,0,0,2'b10,2,0,0), 4);
    add(0, 0, ex(0,0,0,2'b00,2,0,0));
    add(0, 0, ex(0,1,0,2'b00,2,0,0));
    add(0, 0, ex(0,0,0,2'b00,2,0,0), 3);

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].s;
      btn   = vecs[i].b;
      tick();
      chk($sformatf("vec%0d", i), outs(), vecs[i].e);
    end
    start = 1'b0;
    btn   = 2'b00;

    // round 2 entry
    press(2'b01);
    chk("r2_accept0_next", o_next, 1);
    chk("r2_accept0_led", o_led, 2'b01);
    tick();
    press(2'b10);
    chk("r2_accept1_led", o_led, 2'b10);
    tick();
    chk("r3_rewind", {o_start_over, o_level}, {1'b1, 8'd3});

    // round 3 replay: 24 cycles from rewind to input
    c_so = 0; c_nx = 0; c_lit = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      c_so  += int'(o_start_over);
      c_nx  += int'(o_next);
      c_lit += int'(o_led != 2'b00);
    end
    chk("r3_show_start_over", c_so, 1);
    chk("r3_show_next", c_nx, 2);
    chk("r3_show_lit", c_lit, 12);

    press(2'b01); tick();
    press(2'b10); tick();
    press(2'b10);
    chk("r3_final_accept", {o_next, o_win}, 2'b10);
    tick();
    chk("win_state", {o_win, o_fail, o_led, o_level}, {1'b1, 1'b0, 2'b11, 8'd3});

    // wrong first press in round 2
    begin_game();
    chk("restart_from_win", o_win, 0);
    tick(11);
    press(2'b01);
    tick(18);
    chk("r2_input_reached", outs(), ex(0,0,0,2'b00,2,0,0));
    press(2'b10);
    chk("wrong_press_fail", {o_fail, o_led, o_next}, {1'b1, 2'b00, 1'b0});

    // timeout
    begin_game();
    chk("restart_from_lose", o_fail, 0);
    tick(11);
    tick(19);
    chk("timeout_not_yet", o_fail, 0);
    tick();
    chk("timeout_fail", o_fail, 1);

    // both buttons
    begin_game();
    tick(11);
    press(2'b11);
    chk("both_btn_fail", o_fail, 1);

    // reset mid SHOW_ON
    begin_game();
    tick(3);
    chk("pre_reset_led", o_led, 2'b01);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", outs(), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset_idle", outs(), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_reset_seed", {o_randomize, o_start_over}, 2'b10);
    tick();
    chk("post_reset_rewind", {o_randomize, o_start_over}, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/simon_game_controller.md
# simon_game_controller

- Game controller for the two-button Simon game; sits directly downstream of `sequence_generator`.
- Drives the generator's `randomize`, `start_over` and `next` strobes and consumes its one-hot `seq`.
- Plays the first `level` elements of the sequence on two LEDs, then checks the player's button presses against the same elements.
- Each fully correct round lengthens the sequence by one, up to `MAX_LEN`; a wrong press or a timeout ends the game.

## Interface
- `ON_CYCLES`, default 25_000_000: LED on-time per shown element.
- `OFF_CYCLES`, default 12_500_000: dark gap after each shown element, and before input opens.
- `TIMEOUT_CYCLES`, default 250_000_000: maximum wait per press; 0 disables the timeout.
- `MAX_LEN`, default 16: sequence length that wins the game (1 ≤ `MAX_LEN` ≤ 255).

- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: one-cycle pulse that begins a new game.
- `btn` input 2: debounced one-cycle press pulses, one-hot per button.
- `seq` input 2: current one-hot element from `sequence_generator`.
- `randomize` output 1: strobe to the generator, reseeds it.
- `start_over` output 1: strobe to the generator, rewinds it to the sequence start.
- `next` output 1: strobe to the generator, advances one element.
- `led` output 2: player LEDs.
- `level` output 8: current round length; 0 when idle.
- `win` output 1: high while in WIN.
- `fail` output 1: high while in LOSE.

## Operation
- All outputs are registered Moore outputs, decoded from the state.
- Reset value of every output is 0; reset enters IDLE.
- Reset mid-game aborts immediately. The generator is not reset; the next game reseeds it.
- Internal registers:
  - `idx` (8 bit): elements shown or entered in this pass.
  - `len` (8 bit): drives `level`.
  - `timer`: down-counter sized to the largest of `ON_CYCLES`, `OFF_CYCLES`, `TIMEOUT_CYCLES`.
- States and transitions:
  - IDLE: on `start` → SEED.
  - SEED (1 cycle): `randomize`=1. Set `len`=1. → REWIND.
  - REWIND (1 cycle): `start_over`=1. Clear `idx`. → SHOW_ON if showing, GAP if entering input.
  - SHOW_ON: `led`=`seq` for `ON_CYCLES`. → SHOW_OFF.
  - SHOW_OFF: `led`=0 for `OFF_CYCLES`. Increment `idx`. If `idx`+1=`len` → REWIND (input pass); else → STEP.
  - STEP (1 cycle): `next`=1. → SHOW_ON.
  - GAP: `led`=0 for `OFF_CYCLES`. → INPUT.
  - INPUT: `led`=`btn` is echoed combinationally into the register.
    - If `btn`≠0: `btn`=`seq` → ACCEPT, else → LOSE.
    - `btn`=2'b11 always counts as a mismatch.
    - Timer expiry → LOSE.
  - ACCEPT (1 cycle): `next`=1. Increment `idx`.
    - If `idx`+1<`len` → INPUT (timer restarted).
    - Else if `len`=`MAX_LEN` → WIN.
    - Else increment `len` → REWIND (show pass).
  - WIN: `led`=2'b11, `win`=1. On `start` → SEED.
  - LOSE: `led`=2'b00, `fail`=1. On `start` → SEED.
- `start` is ignored in all states except IDLE, WIN and LOSE.
- `btn` is ignored outside INPUT. A press and a timeout in the same cycle resolve as the press.

## Timing
- A strobe issued in cycle N takes effect at the end-of-N edge, so `seq` is valid from N+1.
- Every state following SEED, REWIND, STEP or ACCEPT therefore samples an up-to-date `seq`.
- SEED always precedes REWIND by exactly one cycle, so the rewind loads the new seed.
- SHOW_ON lasts exactly `ON_CYCLES` cycles.
- SHOW_OFF and GAP each last exactly `OFF_CYCLES` cycles.
- A round of length L takes L·(`ON_CYCLES`+`OFF_CYCLES`) + (L−1) + 1 + `OFF_CYCLES` + 1 cycles from its REWIND to INPUT.
- Press-to-decision latency is 1 cycle. `led` echoes the press one cycle after it.
- `TIMEOUT_CYCLES` is counted from INPUT entry, and counting restarts at each accepted press.

## Structure
- Package `simon_pkg` holds:
  - the state enumeration;
  - the `LEVEL_W`=8 constant;
  - the default timing constants shared with the debouncer and top level.
- Sub-module `phase_timer`:
  - loadable down-counter with a `done` flag;
  - instanced once and reloaded on every timed-state entry.
- The FSM plus counters fit in roughly 200 lines.

## Test plan
Parameters: `ON_CYCLES`=4, `OFF_CYCLES`=2, `TIMEOUT_CYCLES`=20, `MAX_LEN`=3. A behavioural model of `sequence_generator` with fixed sequence 01,10,10 follows any reseed.
- Reset mid-SHOW_ON → all outputs 0 in the same cycle; IDLE; `start` → `randomize` one cycle, then `start_over` the next.
- `start`, then observe `led`: 2'b01 for 4 cycles, 0 for 2, then GAP; `level`=1.
- Press `btn`=01 in INPUT → `next` next cycle; `level`=2; replay shows 01 then 10, with `next` exactly once between them.
- Full correct entry for rounds 1–3 → `win`=1 and `led`=11 after the third-round final press; `level`=3.
- Round 2, press 10 as the first element → `fail`=1 one cycle later; `start` restarts with `level`=1.
- No press for 20 cycles in INPUT → `fail`=1. Press 11 → `fail`=1. Presses during SHOW ignored: `idx`/`led` unaffected.
